cordic_sweep_seq: RTL and testbench

- Upstream master for the cordicci custom-instruction unit.
- Generates an angle sweep (start angle, step, count) and runs one three-op transaction per point: n=0 launches with the angle, n=1 reads cos, n=2 reads sin.
- Pushes each {index, cos, sin} result into a small FIFO for software or a downstream consumer.
- Replaces per-point Nios instruction issue for table builds and DMA-fed plots.

---
 rtl/cordic_seq_pkg.sv | 30 +++
 rtl/cordic_seq_fifo.sv | 58 +++++
 rtl/cordic_sweep_seq.sv | 234 +++++++++++++++++++++++
 tb/tb_cordic_sweep_seq.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_seq_pkg.sv
// Shared types and constants for the cordicci sweep sequencer: FSM states,
// cordicci opcodes and the result FIFO entry layout.
package cordic_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_W_ANG,
        ST_RD_COS,
        ST_W_COS,
        ST_RD_SIN,
        ST_W_SIN,
        ST_PUSH,
        ST_FIN
    } seq_state_t;

    localparam logic [7:0] CI_OP_LAUNCH = 8'd0;
    localparam logic [7:0] CI_OP_COS    = 8'd1;
    localparam logic [7:0] CI_OP_SIN    = 8'd2;

    // Index width stored in the FIFO; the top's IDX_W defaults to this.
    localparam int SEQ_IDX_W = 16;

    typedef struct packed {
        logic [SEQ_IDX_W-1:0] idx;
        logic [31:0]          cos;
        logic [31:0]          sin;
    } fifo_entry_t;

endpackage

// File: rtl/cordic_seq_fifo.sv
// First-word-fall-through result FIFO. Power-of-two depth, wrapping pointers
// plus an occupancy counter; a pop in the same cycle frees room for a push.
module cordic_seq_fifo #(
    parameter int WIDTH = 80,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    count_reg;
    logic             do_pop;
    logic             do_push;

    assign do_pop  = pop && (count_reg != '0);
    assign do_push = push && ((count_reg != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_reg + CW'(do_push) - CW'(do_pop);
        end
    end

    // Head is masked while empty so a flushed FIFO presents zeros, not stale data.
    assign rd_data = empty ? '0 : mem[rd_ptr_reg];
    assign full    = (count_reg == CW'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;

endmodule

// File: rtl/cordic_sweep_seq.sv
// Angle-sweep master for the cordicci unit: one launch/cos/sin transaction per
// point, results queued in a FWFT FIFO. Optional watchdog: CORDIC_SEQ_TIMEOUT_EN.
module cordic_sweep_seq
    import cordic_seq_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int IDX_W       = SEQ_IDX_W,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_angle0,
    input  logic [31:0]      cfg_step,
    input  logic [IDX_W-1:0] cfg_count,
    output logic             busy,
    output logic             sweep_done,
    output logic [31:0]      ci_dataa,
    output logic [31:0]      ci_datab,
    output logic [7:0]       ci_n,
    output logic             ci_start,
    output logic             ci_clk_en,
    input  logic [31:0]      ci_result,
    input  logic             ci_done,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [31:0]      out_cos,
    output logic [31:0]      out_sin,
    output logic             err_timeout
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    seq_state_t       state_reg;
    logic [31:0]      angle_reg;
    logic [31:0]      step_reg;
    logic [31:0]      cos_reg;
    logic [31:0]      sin_reg;
    logic [IDX_W-1:0] remaining_reg;
    logic [IDX_W-1:0] idx_reg;
    logic [31:0]      ci_dataa_reg;
    logic [7:0]       ci_n_reg;
    logic             ci_start_reg;
    logic             ci_clk_en_reg;
    logic             busy_reg;
    logic             sweep_done_reg;

    fifo_entry_t      wr_entry;
    fifo_entry_t      rd_entry;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CW-1:0]    fifo_count;
    logic             fifo_pop;
    logic             fifo_push;
    logic             can_push;
    logic [31:0]      next_angle;
    logic             timeout_hit;

    assign next_angle = angle_reg + step_reg;
    assign fifo_pop   = out_ready && (fifo_count != '0);
    // A same-cycle pop frees a slot, so a full FIFO does not block the push then.
    assign can_push   = !fifo_full || fifo_pop;
    assign fifo_push  = (state_reg == ST_PUSH) && can_push;

    always_comb begin
        wr_entry     = '0;
        wr_entry.idx = SEQ_IDX_W'(idx_reg);
        wr_entry.cos = cos_reg;
        wr_entry.sin = sin_reg;
    end

    cordic_seq_fifo #(
        .WIDTH ($bits(fifo_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_data (wr_entry),
        .pop     (fifo_pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

`ifdef CORDIC_SEQ_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WD_W-1:0] wd_reg;
    logic            err_timeout_reg;
    logic            in_wait;

    assign in_wait     = (state_reg == ST_W_ANG) || (state_reg == ST_W_COS) ||
                         (state_reg == ST_W_SIN);
    assign timeout_hit = in_wait && !ci_done && (wd_reg == WD_W'(TIMEOUT_CYC - 1));

    // The counter restarts with every op request and saturates at the limit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd_reg          <= '0;
            err_timeout_reg <= 1'b0;
        end else begin
            if (ci_start_reg) begin
                wd_reg <= '0;
            end else if (in_wait && (wd_reg != WD_W'(TIMEOUT_CYC - 1))) begin
                wd_reg <= wd_reg + 1'b1;
            end
            if (timeout_hit) begin
                err_timeout_reg <= 1'b1;
            end else if ((state_reg == ST_IDLE) && cfg_start) begin
                err_timeout_reg <= 1'b0;
            end
        end
    end

    assign err_timeout = err_timeout_reg;
`else
    // Watchdog compiled out: this comparison is constant false.
    assign timeout_hit = (TIMEOUT_CYC < 0);
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_IDLE;
            angle_reg      <= '0;
            step_reg       <= '0;
            cos_reg        <= '0;
            sin_reg        <= '0;
            remaining_reg  <= '0;
            idx_reg        <= '0;
            ci_dataa_reg   <= '0;
            ci_n_reg       <= '0;
            ci_start_reg   <= 1'b0;
            ci_clk_en_reg  <= 1'b0;
            busy_reg       <= 1'b0;
            sweep_done_reg <= 1'b0;
        end else begin
            ci_clk_en_reg  <= 1'b1;
            ci_start_reg   <= 1'b0;
            sweep_done_reg <= 1'b0;
            if (timeout_hit) begin
                state_reg      <= ST_FIN;
                sweep_done_reg <= 1'b1;
            end else begin
                // Op outputs are loaded on entry to LAUNCH/RD_* so the request
                // pulse and its operands appear together and hold until done.
                case (state_reg)
                    ST_IDLE: begin
                        if (cfg_start) begin
                            angle_reg     <= cfg_angle0;
                            step_reg      <= cfg_step;
                            remaining_reg <= cfg_count;
                            idx_reg       <= '0;
                            busy_reg      <= 1'b1;
                            if (cfg_count == '0) begin
                                state_reg      <= ST_FIN;
                                sweep_done_reg <= 1'b1;
                            end else begin
                                state_reg    <= ST_LAUNCH;
                                ci_start_reg <= 1'b1;
                                ci_n_reg     <= CI_OP_LAUNCH;
                                ci_dataa_reg <= cfg_angle0;
                            end
                        end
                    end
                    ST_LAUNCH: state_reg <= ST_W_ANG;
                    ST_W_ANG: begin
                        if (ci_done) begin
                            state_reg    <= ST_RD_COS;
                            ci_start_reg <= 1'b1;
                            ci_n_reg     <= CI_OP_COS;
                        end
                    end
                    ST_RD_COS: state_reg <= ST_W_COS;
                    ST_W_COS: begin
                        if (ci_done) begin
                            cos_reg      <= ci_result;
                            state_reg    <= ST_RD_SIN;
                            ci_start_reg <= 1'b1;
                            ci_n_reg     <= CI_OP_SIN;
                        end
                    end
                    ST_RD_SIN: state_reg <= ST_W_SIN;
                    ST_W_SIN: begin
                        if (ci_done) begin
                            sin_reg   <= ci_result;
                            state_reg <= ST_PUSH;
                        end
                    end
                    ST_PUSH: begin
                        if (can_push) begin
                            angle_reg     <= next_angle;
                            idx_reg       <= idx_reg + 1'b1;
                            remaining_reg <= remaining_reg - 1'b1;
                            if (remaining_reg != IDX_W'(1)) begin
                                state_reg    <= ST_LAUNCH;
                                ci_start_reg <= 1'b1;
                                ci_n_reg     <= CI_OP_LAUNCH;
                                ci_dataa_reg <= next_angle;
                            end else begin
                                state_reg      <= ST_FIN;
                                sweep_done_reg <= 1'b1;
                            end
                        end
                    end
                    ST_FIN: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                    default: begin
                        state_reg <= ST_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = busy_reg;
    assign sweep_done = sweep_done_reg;
    assign ci_dataa   = ci_dataa_reg;
    assign ci_datab   = 32'd0;
    assign ci_n       = ci_n_reg;
    assign ci_start   = ci_start_reg;
    assign ci_clk_en  = ci_clk_en_reg;
    assign out_valid  = !fifo_empty;
    assign out_index  = IDX_W'(rd_entry.idx);
    assign out_cos    = rd_entry.cos;
    assign out_sin    = rd_entry.sin;

endmodule

// File: tb/tb_cordic_sweep_seq.sv
// Self-checking bench for cordic_sweep_seq: a cordicci stand-in answering 5
// cycles after each request, table-driven sweeps plus hand-written corner cases.
module tb_cordic_sweep_seq;

    localparam int IDX_W = 16;
    localparam int DEPTH = 4;
    localparam int TO    = 64;
    localparam int LAT   = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             cfg_start;
    logic [31:0]      cfg_angle0;
    logic [31:0]      cfg_step;
    logic [IDX_W-1:0] cfg_count;
    logic             busy;
    logic             sweep_done;
    logic [31:0]      ci_dataa;
    logic [31:0]      ci_datab;
    logic [7:0]       ci_n;
    logic             ci_start;
    logic             ci_clk_en;
    logic [31:0]      ci_result = 32'd0;
    logic             ci_done = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [IDX_W-1:0] out_index;
    logic [31:0]      out_cos;
    logic [31:0]      out_sin;
    logic             err_timeout;

    cordic_sweep_seq #(
        .FIFO_DEPTH  (DEPTH),
        .IDX_W       (IDX_W),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cfg_start   (cfg_start),
        .cfg_angle0  (cfg_angle0),
        .cfg_step    (cfg_step),
        .cfg_count   (cfg_count),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .ci_dataa    (ci_dataa),
        .ci_datab    (ci_datab),
        .ci_n        (ci_n),
        .ci_start    (ci_start),
        .ci_clk_en   (ci_clk_en),
        .ci_result   (ci_result),
        .ci_done     (ci_done),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_index   (out_index),
        .out_cos     (out_cos),
        .out_sin     (out_sin),
        .err_timeout (err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] n; logic [31:0] a; } op_t;
    typedef struct { logic [IDX_W-1:0] idx; logic [31:0] c; logic [31:0] s; } ent_t;
    typedef struct { logic [31:0] a0; logic [31:0] st; int cnt; int rmode; logic [31:0] exp_last; } vec_t;

    op_t  exp_ops[$];
    op_t  got_ops[$];
    ent_t exp_fifo[$];

    int checks = 0;
    int errors = 0;

    // cordicci stand-in: distinct, easily recomputed results per opcode
    function automatic logic [31:0] ci_func(logic [7:0] n, logic [31:0] a);
        case (n)
            8'd1:    return a ^ 32'h0C0C_0C0C;
            8'd2:    return a + 32'h0001_3579;
            default: return 32'hDEAD_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end else begin
            $display("ok   %s: %h", name, got);
        end
    endtask

    // ---- cordicci model and output monitor (single process, negedge) ----
    logic       pend = 1'b0;
    int         pend_cnt = 0;
    logic [7:0] pend_n = 8'd0;
    logic [31:0] pend_a = 32'd0;
    bit         hang_cos = 1'b0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         cos_start_cyc = 0;
    int         start_cnt = 0;
    bit         in_sweep = 1'b0;
    int         busy_bad = 0;
    logic       prev_valid = 1'b0;
    logic       valid_at_done = 1'b0;
    logic       prev_at_done = 1'b0;
    logic [IDX_W-1:0] idx_at_done = '0;
    logic [31:0] last_launch = 32'd0;
    int         rmode = 0;

    always @(negedge clk) begin
        cyc++;
        ci_done = 1'b0;
        if (!reset_n) begin
            pend = 1'b0;
        end else begin
            if (ci_start) begin
                chk("no_overlap", 32'(pend), 32'd0);
                got_ops.push_back('{ci_n, ci_dataa});
                start_cnt++;
                pend = 1'b1;
                pend_n = ci_n;
                pend_a = ci_dataa;
                pend_cnt = LAT;
                if (ci_n == 8'd0) last_launch = ci_dataa;
                if (ci_n == 8'd1) cos_start_cyc = cyc;
            end else if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    pend = 1'b0;
                    if (!(hang_cos && pend_n == 8'd1)) begin
                        chk("bus_stable", {ci_n, ci_dataa[23:0]}, {pend_n, pend_a[23:0]});
                        ci_done = 1'b1;
                        ci_result = ci_func(pend_n, pend_a);
                    end
                end
            end
            if (sweep_done) begin
                done_cnt++;
                done_cyc = cyc;
                in_sweep = 1'b0;
                valid_at_done = out_valid;
                prev_at_done = prev_valid;
                idx_at_done = out_index;
            end else if (in_sweep && !busy) begin
                busy_bad++;
            end
            if (out_valid && out_ready) begin
                if (exp_fifo.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got idx %0d required no entry", out_index);
                end else begin
                    ent_t e;
                    e = exp_fifo.pop_front();
                    chk("pop_idx", 32'(out_index), 32'(e.idx));
                    chk("pop_cos", out_cos, e.c);
                    chk("pop_sin", out_sin, e.s);
                end
            end
        end
        prev_valid = out_valid;
    end

    always @(posedge clk) begin
        #1;
        out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // ---- stimulus helpers ----
    task automatic expect_sweep(input logic [31:0] a0, input logic [31:0] st, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            logic [31:0] a;
            a = a0 + st * 32'(i);
            exp_ops.push_back('{8'd0, a});
            exp_ops.push_back('{8'd1, a});
            exp_ops.push_back('{8'd2, a});
            exp_fifo.push_back('{IDX_W'(i), ci_func(8'd1, a), ci_func(8'd2, a)});
        end
    endtask

    task automatic pulse_start(input logic [31:0] a0, input logic [31:0] st, input int cnt);
        @(posedge clk); #1;
        cfg_angle0 = a0;
        cfg_step   = st;
        cfg_count  = IDX_W'(cnt);
        cfg_start  = 1'b1;
        @(posedge clk); #1;
        cfg_start  = 1'b0;
    endtask

    task automatic start_sweep(input logic [31:0] a0, input logic [31:0] st, input int cnt);
        expect_sweep(a0, st, cnt);
        busy_bad = 0;
        pulse_start(a0, st, cnt);
        in_sweep = 1'b1;
    endtask

    task automatic wait_done(input string name, input int base, input int budget);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (done_cnt == base) begin
            errors++;
            $display("FAIL %s_done: got no sweep_done in %0d cycles required pulse", name, budget);
        end
        chk({name, "_busy"}, 32'(busy_bad), 32'd0);
    endtask

    task automatic drain(input string name, input int budget);
        int k = 0;
        rmode = 0;
        while (exp_fifo.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk({name, "_drained_left"}, 32'(exp_fifo.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1 chk({name, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_ops(input string name);
        int n;
        chk({name, "_op_count"}, 32'(got_ops.size()), 32'(exp_ops.size()));
        n = (got_ops.size() < exp_ops.size()) ? got_ops.size() : exp_ops.size();
        for (int i = 0; i < n; i++) begin
            chk({name, "_op_n"}, 32'(got_ops[i].n), 32'(exp_ops[i].n));
            chk({name, "_op_dataa"}, got_ops[i].a, exp_ops[i].a);
        end
        got_ops.delete();
        exp_ops.delete();
    endtask

    vec_t tbl[7];

    initial begin
        int base;
        int s;
        int k;

        tbl[0] = '{32'd16000, 32'd0, 1, 0, 32'd16000};
        tbl[1] = '{32'hFFFF_E0C0, 32'd4000, 5, 0, 32'd8000};
        tbl[2] = '{32'h7FFF_F000, 32'h0000_2000, 2, 1, 32'h8000_1000};
        for (int i = 3; i < 7; i++) begin
            tbl[i].a0 = $urandom;
            tbl[i].st = $urandom;
            tbl[i].cnt = $urandom_range(1, 6);
            tbl[i].rmode = (i == 3) ? 0 : 1;
            tbl[i].exp_last = tbl[i].a0 + tbl[i].st * 32'(tbl[i].cnt - 1);
        end

        reset_n = 1'b0;
        cfg_start = 1'b0;
        cfg_angle0 = 32'd0;
        cfg_step = 32'd0;
        cfg_count = '0;
        #12;
        chk("rst_clk_en", 32'(ci_clk_en), 32'd0);
        chk("rst_outputs", {busy, sweep_done, ci_start, out_valid, err_timeout, ci_n, 16'(out_index)},
            32'd0);
        chk("rst_buses", ci_dataa | ci_datab | out_cos | out_sin, 32'd0);
        @(posedge clk); #1 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("clk_en_after_rst", 32'(ci_clk_en), 32'd1);

        // table-driven sweeps
        for (int v = 0; v < 7; v++) begin
            rmode = tbl[v].rmode;
            base = done_cnt;
            start_sweep(tbl[v].a0, tbl[v].st, tbl[v].cnt);
            wait_done($sformatf("vec%0d", v), base, 3000);
            if (tbl[v].rmode == 0) begin
                chk($sformatf("vec%0d_push_then_done", v), {30'd0, valid_at_done, prev_at_done}, 32'd2);
                chk($sformatf("vec%0d_idx_at_done", v), 32'(idx_at_done), 32'(tbl[v].cnt - 1));
            end
            drain($sformatf("vec%0d", v), 3000);
            chk($sformatf("vec%0d_last_dataa", v), last_launch, tbl[v].exp_last);
            check_ops($sformatf("vec%0d", v));
            chk($sformatf("vec%0d_idle", v), 32'(busy), 32'd0);
        end

        // count=0: done pulse in the FIN cycle after start, no CI traffic
        rmode = 0;
        base = done_cnt;
        start_sweep(32'd5, 32'd5, 0);
        chk("cnt0_done", {29'd0, sweep_done, busy, ci_start}, 32'd6);
        @(posedge clk); #1;
        chk("cnt0_after", {30'd0, sweep_done, busy}, 32'd0);
        check_ops("cnt0");

        // backpressure: 4 entries fill the FIFO, fifth point stalls in PUSH
        rmode = 2;
        base = done_cnt;
        start_sweep(32'd1000, 32'd300, 6);
        repeat (150) @(posedge clk);
        s = start_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("bp_no_ci_start", 32'(start_cnt), 32'(s));
        chk("bp_ops_before_stall", 32'(got_ops.size()), 32'd15);
        chk("bp_state", {30'd0, busy, out_valid}, 32'd3);
        drain("bp", 2000);
        wait_done("bp", base, 100);
        check_ops("bp");

        // cfg_start while busy is ignored
        rmode = 0;
        base = done_cnt;
        start_sweep(32'd100, 32'd10, 3);
        repeat (8) @(posedge clk);
        pulse_start(32'h5555_0000, 32'd7, 9);
        wait_done("midstart", base, 3000);
        drain("midstart", 1000);
        check_ops("midstart");

        // reset in W_COS of the second point, with one entry already queued
        rmode = 2;
        start_sweep(32'd2000, 32'd500, 3);
        k = 0;
        while (got_ops.size() < 5 && k < 500) begin
            @(posedge clk);
            k++;
        end
        chk("rst_mid_reached_cos", 32'(got_ops.size()), 32'd5);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_outputs", {busy, sweep_done, ci_start, out_valid, ci_clk_en, err_timeout, ci_n,
            16'(out_index)}, 32'd0);
        chk("rst_mid_buses", ci_dataa | out_cos | out_sin, 32'd0);
        exp_fifo.delete();
        exp_ops.delete();
        got_ops.delete();
        in_sweep = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        rmode = 0;
        base = done_cnt;
        start_sweep(32'd777, 32'hFFFF_FFFD, 3);
        wait_done("post_rst", base, 3000);
        drain("post_rst", 1000);
        check_ops("post_rst");

`ifdef CORDIC_SEQ_TIMEOUT_EN
        // cos never answers: abort after TO wait cycles, nothing pushed
        hang_cos = 1'b1;
        rmode = 0;
        base = done_cnt;
        exp_ops.push_back('{8'd0, 32'd4242});
        exp_ops.push_back('{8'd1, 32'd4242});
        busy_bad = 0;
        pulse_start(32'd4242, 32'd1, 2);
        in_sweep = 1'b1;
        wait_done("timeout", base, 500);
        chk("timeout_err", 32'(err_timeout), 32'd1);
        chk("timeout_latency", 32'(done_cyc - cos_start_cyc), 32'(TO + 1));
        repeat (3) @(posedge clk);
        #1 chk("timeout_no_push", 32'(out_valid), 32'd0);
        check_ops("timeout");
        hang_cos = 1'b0;
        base = done_cnt;
        start_sweep(32'd9, 32'd1, 1);
        chk("timeout_err_cleared", 32'(err_timeout), 32'd0);
        wait_done("timeout_recover", base, 1000);
        drain("timeout_recover", 500);
        check_ops("timeout_recover");
`else
        chk("err_timeout_tied", 32'(err_timeout), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
